// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Brief    : Single-clock parametrised FIFO with occupancy count, almost-full /
//            almost-empty flags and optional sticky overflow/underflow errors
//            (enabled by defining SYNC_FIFO_ERR_EN).
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  wafull,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] C_DEPTH   = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] C_AFULL   = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] C_AEMPTY  = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] C_ONE     = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];

    logic [ADDR_WIDTH:0]   wptr_q,  wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q,  rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    // Flags decode the registered count only; a write is never visible to a
    // read in the same cycle.
    assign wfull   = (count_q == C_DEPTH);
    assign rempty  = (count_q == '0);
    assign wafull  = (count_q >= C_AFULL);
    assign raempty = (count_q <= C_AEMPTY);
    assign count   = count_q;
    assign rdata   = rdata_q;

    always_comb begin
        w_wr_ok = winc & ~wfull;
        w_rd_ok = rinc & ~rempty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rdata_d = rdata_q;
        if (w_wr_ok) begin
            wptr_d = wptr_q + C_ONE;
        end
        if (w_rd_ok) begin
            rptr_d  = rptr_q + C_ONE;
            rdata_d = mem_q[rptr_q[ADDR_WIDTH-1:0]];
        end
        case ({w_wr_ok, w_rd_ok})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    // The wrapping pointer distance must always equal the tracked occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((wptr_q - rptr_q) == count_q);
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (winc & wfull);
        underflow_d = underflow_q | (rinc & rempty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
`default_nettype wire
